// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Optional build macro: CLK_DIV_SYNC_EN (adds a global phase-align input).
package clk_div_pkg;

    // Widest ratio the helper below can handle; DIV_W must not exceed this.
    localparam int MAX_DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } chan_state_t;

    // Length of the high phase for a given ratio: odd ratios get the extra cycle high.
    function automatic logic [MAX_DIV_W:0] high_len(input logic [MAX_DIV_W-1:0] div);
        return ({1'b0, div} + 1'b1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: run/stop FSM, period counter, active and pending ratio,
// registered divided output and period-start tick.
// Optional build macro: CLK_DIV_SYNC_EN (adds the sync restart input).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_div,
    output logic             tick,
    output logic             pend,
    output logic             err
);

    chan_state_t      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] nxt_div_q, nxt_div_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;

    logic             sync_i;
    logic             load_ok;
    logic             wrap;
    logic [MAX_DIV_W:0] hi;

`ifdef CLK_DIV_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // A zero ratio is never accepted; it only raises the sticky error.
    assign load_ok = load && (div_in != '0);
    // Last cycle of the current period.
    assign wrap    = (cnt_q == cur_div_q - DIV_W'(1));
    assign hi      = high_len(MAX_DIV_W'(cur_div_q));

    // Next-state, counter, ratio bookkeeping and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        nxt_div_d = nxt_div_q;
        pend_d    = pend_q;
        err_d     = err_q;
        clk_div_d = 1'b0;
        tick_d    = 1'b0;

        if (load && (div_in == '0)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    cur_div_d = div_in;
                end
                if (en) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    clk_div_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            default: begin
                if (sync_i || wrap) begin
                    // Period boundary (or forced restart): a same-cycle load wins
                    // over an older pending ratio.
                    if (load_ok) begin
                        cur_div_d = div_in;
                        pend_d    = 1'b0;
                    end else if (pend_q) begin
                        cur_div_d = nxt_div_q;
                        pend_d    = 1'b0;
                    end
                    cnt_d = '0;
                    if (sync_i || en) begin
                        // A forced restart keeps a stopping channel stopping.
                        state_d   = (sync_i && !en) ? STOP : RUN;
                        clk_div_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q + DIV_W'(1);
                    state_d   = en ? RUN : STOP;
                    clk_div_d = ((MAX_DIV_W+1)'(cnt_d) < hi);
                    if (load_ok) begin
                        nxt_div_d = div_in;
                        pend_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset forces everything low at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_div_q <= DIV_W'(DEFAULT_DIV);
            nxt_div_q <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            nxt_div_q <= nxt_div_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div = clk_div_q;
    assign tick    = tick_q;
    assign pend    = pend_q;
    assign err     = err_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider: CHANNELS independent
// clk_div_chan instances, each taking its own DIV_W-bit slice of div_in.
// Optional build macro: CLK_DIV_SYNC_EN (sync input phase-aligns all running channels).
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*DIV_W-1:0] div_in,
`ifdef CLK_DIV_SYNC_EN
    input  logic                      sync,
`endif
    output logic [CHANNELS-1:0]       clk_div,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pend,
    output logic [CHANNELS-1:0]       err
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            clk_div_chan #(
                .DIV_W      (DIV_W),
                .DEFAULT_DIV(DEFAULT_DIV)
            ) u_chan (
                .clk    (clk),
                .reset  (reset),
                .en     (en[gi]),
                .load   (load[gi]),
                .div_in (div_in[gi*DIV_W +: DIV_W]),
`ifdef CLK_DIV_SYNC_EN
                .sync   (sync),
`endif
                .clk_div(clk_div[gi]),
                .tick   (tick[gi]),
                .pend   (pend[gi]),
                .err    (err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed vector table, reset sequence, then random
// traffic checked against a period-level reference model.
module tb_clk_div_prog;

    localparam int NCH = 4;
    localparam int DW  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NCH-1:0]     en;
    logic [NCH-1:0]     load;
    logic [NCH*DW-1:0]  div_in;
`ifdef CLK_DIV_SYNC_EN
    logic               sync = 1'b0;
`endif
    logic [NCH-1:0]     clk_div;
    logic [NCH-1:0]     tick;
    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     err;

    clk_div_prog #(.CHANNELS(NCH), .DIV_W(DW), .DEFAULT_DIV(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .load   (load),
        .div_in (div_in),
`ifdef CLK_DIV_SYNC_EN
        .sync   (sync),
`endif
        .clk_div(clk_div),
        .tick   (tick),
        .pend   (pend),
        .err    (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: where each channel sits inside its current period.
    bit m_run  [NCH];
    int m_pos  [NCH];
    int m_cur  [NCH];
    int m_nxt  [NCH];
    bit m_pend [NCH];
    bit m_err  [NCH];

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0; m_pos[c] = 0; m_cur[c] = 2;
            m_nxt[c] = 0; m_pend[c] = 0; m_err[c] = 0;
        end
    endfunction

    function automatic void model_step(input int c, input bit e, input bit l, input int d);
        bit ok;
        ok = l && (d != 0);
        if (l && d == 0) m_err[c] = 1;
        if (!m_run[c]) begin
            if (ok) m_cur[c] = d;
            if (e) begin
                m_run[c] = 1;
                m_pos[c] = 0;
            end
        end else if (m_pos[c] == m_cur[c] - 1) begin
            if (ok) m_cur[c] = d;
            else if (m_pend[c]) m_cur[c] = m_nxt[c];
            m_pend[c] = 0;
            m_pos[c]  = 0;
            if (!e) m_run[c] = 0;
        end else begin
            m_pos[c] = m_pos[c] + 1;
            if (ok) begin
                m_nxt[c]  = d;
                m_pend[c] = 1;
            end
        end
    endfunction

    function automatic bit exp_clk(input int c);
        return m_run[c] && (m_pos[c] < (m_cur[c] + 1) / 2);
    endfunction

    function automatic bit exp_tick(input int c);
        return m_run[c] && (m_pos[c] == 0);
    endfunction

    task automatic check(input string name, input int c, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s ch%0d: got %b, expected %b (t=%0t)", name, c, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare every channel after the edge.
    task automatic cycle(input logic [NCH-1:0] e, input logic [NCH-1:0] l,
                         input logic [NCH*DW-1:0] d);
        en = e; load = l; div_in = d;
        for (int c = 0; c < NCH; c++) model_step(c, e[c], l[c], int'(d[c*DW +: DW]));
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            check("model_clk_div", c, clk_div[c], exp_clk(c));
            check("model_tick",    c, tick[c],    exp_tick(c));
            check("model_pend",    c, pend[c],    m_pend[c]);
            check("model_err",     c, err[c],     m_err[c]);
        end
    endtask

    typedef struct {
        int ch;
        bit en;
        bit ld;
        int d;
        bit ec;
        bit et;
        bit ep;
        bit ee;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int ch, input bit e, input bit l, input int d,
                                input bit ec, input bit et, input bit ep, input bit ee);
        vec_t v;
        v.ch = ch; v.en = e; v.ld = l; v.d = d;
        v.ec = ec; v.et = et; v.ep = ep; v.ee = ee;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0]    e_r;
        logic [NCH-1:0]    l_r;
        logic [NCH*DW-1:0] d_r;

        // ch0 default ratio 2
        add(0,1,0,0, 1,1,0,0); add(0,1,0,0, 0,0,0,0);
        add(0,1,0,0, 1,1,0,0); add(0,1,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0);
        // ch1 load 5 while idle, then run two periods and stop at the wrap
        add(1,0,1,5, 0,0,0,0);
        add(1,1,0,0, 1,1,0,0); add(1,1,0,0, 1,0,0,0); add(1,1,0,0, 1,0,0,0);
        add(1,1,0,0, 0,0,0,0); add(1,1,0,0, 0,0,0,0);
        add(1,1,0,0, 1,1,0,0); add(1,1,0,0, 1,0,0,0); add(1,1,0,0, 1,0,0,0);
        add(1,1,0,0, 0,0,0,0); add(1,1,0,0, 0,0,0,0);
        add(1,0,0,0, 0,0,0,0);
        // ch2 ratio 4, load 6 at cnt=1, pending until the wrap
        add(2,0,1,4, 0,0,0,0);
        add(2,1,0,0, 1,1,0,0); add(2,1,0,0, 1,0,0,0);
        add(2,1,1,6, 0,0,1,0); add(2,1,0,0, 0,0,1,0);
        add(2,1,0,0, 1,1,0,0);
        add(2,0,0,0, 1,0,0,0); add(2,0,0,0, 1,0,0,0); add(2,0,0,0, 0,0,0,0);
        add(2,0,0,0, 0,0,0,0); add(2,0,0,0, 0,0,0,0); add(2,0,0,0, 0,0,0,0);
        // ch0 ratio 6: drop en at cnt=1, re-raise at cnt=4, then drop for good
        add(0,0,1,6, 0,0,0,0);
        add(0,1,0,0, 1,1,0,0); add(0,1,0,0, 1,0,0,0);
        add(0,0,0,0, 1,0,0,0); add(0,0,0,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0);
        add(0,1,0,0, 0,0,0,0); add(0,1,0,0, 1,1,0,0);
        add(0,0,0,0, 1,0,0,0); add(0,0,0,0, 1,0,0,0); add(0,0,0,0, 0,0,0,0);
        add(0,0,0,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0);
        // ch3 load 0 rejected: ratio stays 2, err sticks
        add(3,0,1,0, 0,0,0,1);
        add(3,1,0,0, 1,1,0,1); add(3,1,0,0, 0,0,0,1);
        add(3,1,0,0, 1,1,0,1); add(3,1,0,0, 0,0,0,1);
        add(3,0,0,0, 0,0,0,1);

        model_reset();
        reset = 1'b1; en = '0; load = '0; div_in = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            check("reset_clk_div", c, clk_div[c], 1'b0);
            check("reset_tick",    c, tick[c],    1'b0);
            check("reset_pend",    c, pend[c],    1'b0);
            check("reset_err",     c, err[c],     1'b0);
        end
        $display("reset released");
        reset = 1'b0;

        foreach (vecs[k]) begin
            e_r = '0; l_r = '0; d_r = '0;
            e_r[vecs[k].ch] = vecs[k].en;
            l_r[vecs[k].ch] = vecs[k].ld;
            d_r[vecs[k].ch*DW +: DW] = DW'(vecs[k].d);
            cycle(e_r, l_r, d_r);
            check("vec_clk_div", vecs[k].ch, clk_div[vecs[k].ch], vecs[k].ec);
            check("vec_tick",    vecs[k].ch, tick[vecs[k].ch],    vecs[k].et);
            check("vec_pend",    vecs[k].ch, pend[vecs[k].ch],    vecs[k].ep);
            check("vec_err",     vecs[k].ch, err[vecs[k].ch],     vecs[k].ee);
            $display("vec %0d ch%0d en=%b ld=%b d=%0d -> clk_div=%b tick=%b pend=%b err=%b",
                     k, vecs[k].ch, vecs[k].en, vecs[k].ld, vecs[k].d,
                     clk_div[vecs[k].ch], tick[vecs[k].ch], pend[vecs[k].ch], err[vecs[k].ch]);
        end

        // Reset mid-high-phase with a pending ratio on ch1 (ratio 5)
        cycle(4'b0010, 4'b0000, '0);
        d_r = '0; d_r[1*DW +: DW] = DW'(7);
        cycle(4'b0010, 4'b0010, d_r);
        check("pre_reset_clk_div", 1, clk_div[1], 1'b1);
        check("pre_reset_pend",    1, pend[1],    1'b1);
        $display("seq ch1 running div=5 pend=%b clk_div=%b, asserting reset", pend[1], clk_div[1]);
        reset = 1'b1;
        #2;
        for (int c = 0; c < NCH; c++) begin
            check("async_reset_clk_div", c, clk_div[c], 1'b0);
            check("async_reset_tick",    c, tick[c],    1'b0);
            check("async_reset_pend",    c, pend[c],    1'b0);
        end
        check("async_reset_err", 3, err[3], 1'b0);
        model_reset();
        en = '0; load = '0; div_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("seq reset released");

        // Random traffic against the model
        e_r = '0;
        for (int n = 0; n < 1500; n++) begin
            l_r = '0; d_r = '0;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 15) == 0) e_r[c] = ~e_r[c];
                if ($urandom_range(0, 9) == 0) begin
                    l_r[c] = 1'b1;
                    d_r[c*DW +: DW] = DW'($urandom_range(0, 9));
                end
            end
            cycle(e_r, l_r, d_r);
            if (l_r != '0)
                $display("rand %0d en=%b load=%b div_in=%h -> clk_div=%b tick=%b pend=%b err=%b",
                         n, e_r, l_r, d_r, clk_div, tick, pend, err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel runtime-programmable clock divider; parametrised successor to the fixed-ratio divide-by-2N block.
- Each channel produces a divided clock-enable-style waveform plus a one-cycle period tick.
- Supports even and odd ratios, glitch-free ratio change at period boundaries, and glitch-free start/stop.
- Sits beside the system clock root and feeds slow peripherals (UART baud, LED scan, debounce sampling).

Parameters:
- CHANNELS, 4, number of independent divider channels.
- DIV_W, 16, width of each divide ratio and counter.
- DEFAULT_DIV, 2, ratio loaded into every channel at reset; must satisfy 1 <= DEFAULT_DIV < 2**DIV_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  CHANNELS  per-channel run enable.
- load  in  CHANNELS  per-channel ratio load strobe.
- div_in  in  CHANNELS*DIV_W  packed ratios; channel i uses bits [i*DIV_W +: DIV_W].
- clk_div  out  CHANNELS  registered divided outputs.
- tick  out  CHANNELS  registered one-cycle pulse at each period start.
- pend  out  CHANNELS  loaded ratio waiting for period boundary.
- err  out  CHANNELS  sticky: a load with ratio 0 was rejected.

Behaviour:
- Reset (async assert): cnt=0, cur_div=DEFAULT_DIV, nxt_div=0, state=IDLE, clk_div=0, tick=0, pend=0, err=0.
- Per-channel FSM with states IDLE, RUN and STOP.
- Period rule (RUN/STOP): cnt counts 0..cur_div-1 and wraps to 0.
  - hi = (cur_div+1)>>1.
  - clk_div is registered: clk_div <= (cnt_next < hi).
  - tick <= (cnt_next == 0).
  - Odd ratios give a high phase one cycle longer than the low phase, e.g. div=5 gives 3 high, 2 low.
- div=1: clk_div stays 1 and tick stays 1 every cycle while running.
- IDLE -> RUN on en=1.
  - At the next edge: cnt=0, clk_div=1, tick=1.
  - Latency: 1 cycle from en high to clk_div high.
- RUN -> STOP on en=0.
  - The channel keeps counting until it reaches the last cycle of the period (cnt==cur_div-1).
  - It then goes to IDLE with cnt=0 and clk_div=0. No truncated high or low pulse is allowed.
- STOP -> RUN if en returns to 1 before the period ends; counting continues with no disturbance.
- Load with div_in=0: ignored, err[i] <= 1 and stays set until reset.
- Load in IDLE: cur_div <= div_in at that edge; pend stays 0.
- Load in RUN/STOP: nxt_div <= div_in and pend <= 1.
  - At the wrap edge (cnt==cur_div-1): cur_div <= nxt_div, pend <= 0, and the new period uses the new ratio starting from cnt=0.
- Load coinciding with the wrap edge: div_in is applied directly at that wrap; pend stays 0.
- Repeated load while pend=1: the newest value overwrites nxt_div.
- Reset mid-period: everything returns to reset values immediately. Outputs go low asynchronously, and there is no completion of the period.
- Channels are fully independent; no cross-channel phase relation unless CLK_DIV_SYNC_EN is compiled in.

Optional Feature:
- Macro CLK_DIV_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit).
  - sync=1 forces every channel in RUN or STOP to cnt=0, clk_div=1, tick=1 at the next edge, phase-aligning all channels.
  - Any pending ratio is applied at that restart.
  - IDLE channels are unaffected.
  - sync has priority over a normal wrap in the same cycle.
- Undefined: no sync port and no alignment logic.

Decomposition:
- Package clk_div_pkg:
  - state enum (IDLE, RUN, STOP);
  - helper function for hi = (div+1)>>1.
- Sub-module clk_div_chan: one channel containing the FSM, counter, cur/nxt ratio registers and output flops.
- clk_div_prog instantiates CHANNELS copies via generate and slices div_in.

Test Plan:
- Reset, then en[0]=1 with default div=2: clk_div[0] toggles 1,0,1,0 starting 1 cycle after en, and tick[0] pulses on every high.
- load ch1 div_in=5 while IDLE, then en=1: repeating pattern 1,1,1,0,0, tick once per 5 cycles, pend stays 0.
- ch2 running div=4, load 6 at cnt=1: pend=1 until the wrap edge; that period finishes 4 long, then 6-cycle periods (3 high/3 low) follow and pend clears.
- ch0 div=6, en dropped at cnt=1: high phase and low phase complete fully, clk_div ends 0 at cnt=5→IDLE; a second case re-raises en at cnt=4 and the waveform stays unbroken.
- load div_in=0 on ch3: ratio unchanged and err[3]=1 until reset. Separately, assert reset mid-high-phase: clk_div, tick and pend go 0 immediately.
- With CLK_DIV_SYNC_EN, ch0 div=3 and ch1 div=4 at arbitrary phases, pulse sync: both show tick=1 and clk_div=1 on the same next cycle.
